// File: rtl/line_arb_pkg.sv
// Shared types and line geometry for the cacheline memory port arbiter.
package line_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DMD  = 2'd1,
    PF   = 2'd2
  } arb_state_t;

  localparam int LINE_BYTES       = 32;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

endpackage

// File: rtl/line_mem_arbiter_if.sv
// Cacheline adaptor port: the arbiter is master, the adaptor/memory is slave.
interface line_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output read, output write, output address, output wdata,
                  input  rdata, input  resp);
  modport slave  (input  read, input  write, input  address, input  wdata,
                  output rdata, output resp);
endinterface

// File: rtl/line_arb_starve_ctr.sv
// Saturating count of demand grants taken while a prefetch waits.
module line_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam bit          ENABLED = (STARVE_LIMIT > 0);
  localparam int          CW      = ENABLED ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM   = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && ENABLED && (cnt != LIM)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_limit = ENABLED && (cnt == LIM);

endmodule

// File: rtl/line_mem_arbiter.sv
// Shares one cacheline memory port between demand misses and the next-line
// prefetcher; demand reads hitting the in-flight prefetch line ride along on it.
module line_mem_arbiter
  import line_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmd_read,
  input  logic              dmd_write,
  input  logic [ADDR_W-1:0] dmd_address,
  input  logic [LINE_W-1:0] dmd_wdata,
  output logic [LINE_W-1:0] dmd_rdata,
  output logic              dmd_resp,
  input  logic              pf_read,
  input  logic [ADDR_W-1:0] pf_address,
  output logic [LINE_W-1:0] pf_rdata,
  output logic              pf_resp,
  line_mem_arbiter_if.master mem
);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  arb_state_t        state, state_nxt;
  logic              merge_q, merge_nxt, merge_hit;
  logic              read_q, write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              grant_dmd, grant_pf, at_limit;

  always_comb begin
    state_nxt = state;
    merge_nxt = merge_q;
    merge_hit = 1'b0;
    grant_dmd = 1'b0;
    grant_pf  = 1'b0;
    dmd_resp  = 1'b0;
    pf_resp   = 1'b0;
    case (state)
      IDLE: begin
        if ((dmd_read || dmd_write) && !(pf_read && at_limit)) begin
          grant_dmd = 1'b1;
          state_nxt = DMD;
        end else if (pf_read) begin
          grant_pf  = 1'b1;
          state_nxt = PF;
        end
      end
      DMD: begin
        if (mem.resp) begin
          dmd_resp  = 1'b1;
          state_nxt = IDLE;
        end
      end
      PF: begin
        // Only reads may share the prefetch; a write must reach memory itself.
        merge_hit = dmd_read && !dmd_write &&
                    (dmd_address[ADDR_W-1:LINE_OFFSET_BITS] == addr_q[ADDR_W-1:LINE_OFFSET_BITS]);
        if (mem.resp) begin
          pf_resp   = 1'b1;
          dmd_resp  = merge_q || merge_hit;
          merge_nxt = 1'b0;
          state_nxt = IDLE;
        end else if (merge_hit) begin
          merge_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      merge_q <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      merge_q <= merge_nxt;
      if (grant_dmd) begin
        read_q  <= !dmd_write;
        write_q <= dmd_write;
        addr_q  <= dmd_address & LINE_MASK;
        wdata_q <= dmd_wdata;
      end else if (grant_pf) begin
        read_q  <= 1'b1;
        write_q <= 1'b0;
        addr_q  <= pf_address & LINE_MASK;
        wdata_q <= '0;
      end else if (mem.resp && (state != IDLE)) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
      end
    end
  end

  line_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (grant_dmd && pf_read),
    .clr      (grant_pf),
    .at_limit (at_limit)
  );

  assign mem.read    = read_q;
  assign mem.write   = write_q;
  assign mem.address = addr_q;
  assign mem.wdata   = wdata_q;
  assign dmd_rdata   = mem.rdata;
  assign pf_rdata    = mem.rdata;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench: stimulus pushes expected memory requests and responses,
// a negedge monitor pops and compares them as the arbiter presents them.
module tb_line_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              d;
    logic              p;
    logic              chk;
    logic [LINE_W-1:0] data;
  } resp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              dmd_read = 1'b0, dmd_write = 1'b0;
  logic [ADDR_W-1:0] dmd_address = '0;
  logic [LINE_W-1:0] dmd_wdata = '0;
  logic [LINE_W-1:0] dmd_rdata;
  logic              dmd_resp;
  logic              pf_read = 1'b0;
  logic [ADDR_W-1:0] pf_address = '0;
  logic [LINE_W-1:0] pf_rdata;
  logic              pf_resp;

  int n_checks = 0;
  int n_fail   = 0;

  req_t  req_q[$];
  resp_t resp_q[$];

  line_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  line_mem_arbiter #(
    .STARVE_LIMIT(2),
    .ADDR_W      (ADDR_W),
    .LINE_W      (LINE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dmd_read   (dmd_read),
    .dmd_write  (dmd_write),
    .dmd_address(dmd_address),
    .dmd_wdata  (dmd_wdata),
    .dmd_rdata  (dmd_rdata),
    .dmd_resp   (dmd_resp),
    .pf_read    (pf_read),
    .pf_address (pf_address),
    .pf_rdata   (pf_rdata),
    .pf_resp    (pf_resp),
    .mem        (bus.master)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [LINE_W-1:0] w);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = w;
    req_q.push_back(r);
  endtask

  task automatic push_resp(input logic d, input logic p, input logic chk,
                           input logic [LINE_W-1:0] data);
    resp_t e;
    e.d = d; e.p = p; e.chk = chk; e.data = data;
    resp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe();
    int t;
    t = 0;
    while (!(bus.read || bus.write) && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("strobe_timeout", 1'b0, 1'b1);
  endtask

  task automatic pulse_resp(input logic [LINE_W-1:0] d);
    bus.rdata = d;
    bus.resp  = 1'b1;
    tick();
    bus.resp  = 1'b0;
    bus.rdata = '0;
  endtask

  task automatic serve(input logic [LINE_W-1:0] d, input int lat);
    wait_strobe();
    repeat (lat) tick();
    pulse_resp(d);
  endtask

  // Monitor: new strobe rise => one memory request; any resp pulse => one response.
  initial begin : monitor
    logic  prev;
    req_t  r;
    resp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.read || bus.write) && !prev) begin
        if (req_q.size() == 0) begin
          check("unexpected_mem_req", {224'd0, bus.address}, '1);
        end else begin
          r = req_q.pop_front();
          check("req_write", bus.write, r.wr);
          check("req_read", bus.read, !r.wr);
          check("req_addr", bus.address, r.addr);
          if (r.wr) check("req_wdata", bus.wdata, r.wdata);
        end
      end
      prev = bus.read || bus.write;
      if (dmd_resp || pf_resp) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", {dmd_resp, pf_resp}, '0);
        end else begin
          e = resp_q.pop_front();
          check("resp_dmd", dmd_resp, e.d);
          check("resp_pf", pf_resp, e.p);
          if (e.chk && dmd_resp) check("resp_dmd_data", dmd_rdata, e.data);
          if (e.chk && pf_resp)  check("resp_pf_data", pf_rdata, e.data);
        end
      end
    end
  end

  initial begin : stimulus
    logic [LINE_W-1:0] wb;
    bus.rdata = '0;
    bus.resp  = 1'b0;
    wb = {8{32'hDEAD_BEEF}};

    // Reset state
    repeat (2) tick();
    check("rst_mem_read", bus.read, 1'b0);
    check("rst_mem_write", bus.write, 1'b0);
    check("rst_mem_address", bus.address, '0);
    check("rst_mem_wdata", bus.wdata, '0);
    check("rst_dmd_resp", dmd_resp, 1'b0);
    check("rst_pf_resp", pf_resp, 1'b0);
    rst = 1'b1;
    tick();

    // Lone demand read
    push_req(1'b0, 32'h0000_1040, '0);
    push_resp(1'b1, 1'b0, 1'b1, {32{8'hA5}});
    dmd_read = 1'b1; dmd_address = 32'h0000_1040;
    tick();
    check("t1_strobe_next_cycle", bus.read, 1'b1);
    check("t1_addr_next_cycle", bus.address, 32'h0000_1040);
    serve({32{8'hA5}}, 1);
    dmd_read = 1'b0;
    repeat (2) tick();

    // Simultaneous demand and prefetch: demand first, prefetch after one idle cycle
    push_req(1'b0, 32'h0000_0100, '0);
    push_req(1'b0, 32'h0000_0120, '0);
    push_resp(1'b1, 1'b0, 1'b1, {32{8'h11}});
    push_resp(1'b0, 1'b1, 1'b1, {32{8'h22}});
    dmd_read = 1'b1; dmd_address = 32'h0000_0100;
    pf_read  = 1'b1; pf_address  = 32'h0000_0120;
    serve({32{8'h11}}, 1);
    dmd_read = 1'b0;
    check("t2_idle_gap", bus.read, 1'b0);
    tick();
    check("t2_pf_strobe", bus.read, 1'b1);
    check("t2_pf_addr", bus.address, 32'h0000_0120);
    serve({32{8'h22}}, 1);
    pf_read = 1'b0;
    repeat (2) tick();

    // Starvation limit 2: D, D, P, D; then counter restarts from zero
    push_req(1'b0, 32'h0000_3100, '0);
    push_req(1'b0, 32'h0000_3140, '0);
    push_req(1'b0, 32'h0000_3000, '0);
    push_req(1'b0, 32'h0000_3180, '0);
    push_req(1'b0, 32'h0000_31C0, '0);
    push_req(1'b0, 32'h0000_3200, '0);
    push_resp(1'b1, 1'b0, 1'b1, {32{8'h31}});
    push_resp(1'b1, 1'b0, 1'b1, {32{8'h32}});
    push_resp(1'b0, 1'b1, 1'b1, {32{8'h33}});
    push_resp(1'b1, 1'b0, 1'b1, {32{8'h34}});
    push_resp(1'b1, 1'b0, 1'b1, {32{8'h35}});
    push_resp(1'b0, 1'b1, 1'b1, {32{8'h36}});
    dmd_read = 1'b1; dmd_address = 32'h0000_3100;
    pf_read  = 1'b1; pf_address  = 32'h0000_3000;
    serve({32{8'h31}}, 0);
    dmd_address = 32'h0000_3140;
    serve({32{8'h32}}, 0);
    dmd_address = 32'h0000_3180;
    serve({32{8'h33}}, 0);
    pf_read = 1'b0;
    serve({32{8'h34}}, 0);
    dmd_address = 32'h0000_31C0;
    pf_read = 1'b1; pf_address = 32'h0000_3200;
    serve({32{8'h35}}, 0);
    dmd_read = 1'b0;
    serve({32{8'h36}}, 0);
    pf_read = 1'b0;
    repeat (2) tick();

    // Demand read merges onto in-flight prefetch of the same line
    push_req(1'b0, 32'h0000_2020, '0);
    push_resp(1'b1, 1'b1, 1'b1, {32{8'h5C}});
    pf_read = 1'b1; pf_address = 32'h0000_2020;
    wait_strobe();
    tick();
    dmd_read = 1'b1; dmd_address = 32'h0000_2024;
    tick();
    pulse_resp({32{8'h5C}});
    dmd_read = 1'b0; pf_read = 1'b0;
    repeat (4) tick();

    // Matching demand appearing in the mem_resp cycle itself still merges
    push_req(1'b0, 32'h0000_4000, '0);
    push_resp(1'b1, 1'b1, 1'b1, {32{8'h6E}});
    pf_read = 1'b1; pf_address = 32'h0000_4000;
    wait_strobe();
    tick();
    dmd_read = 1'b1; dmd_address = 32'h0000_401F;
    pulse_resp({32{8'h6E}});
    dmd_read = 1'b0; pf_read = 1'b0;
    repeat (4) tick();

    // Demand write to the prefetch line does not merge; written back afterwards
    push_req(1'b0, 32'h0000_2020, '0);
    push_req(1'b1, 32'h0000_2020, wb);
    push_resp(1'b0, 1'b1, 1'b1, {32{8'h77}});
    push_resp(1'b1, 1'b0, 1'b0, '0);
    pf_read = 1'b1; pf_address = 32'h0000_2020;
    wait_strobe();
    tick();
    dmd_write = 1'b1; dmd_address = 32'h0000_2020; dmd_wdata = wb;
    tick();
    pulse_resp({32{8'h77}});
    pf_read = 1'b0;
    serve('0, 1);
    dmd_write = 1'b0;
    repeat (2) tick();

    // Reset two cycles into a demand transaction
    push_req(1'b0, 32'h0000_5000, '0);
    dmd_read = 1'b1; dmd_address = 32'h0000_5000;
    wait_strobe();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_read_drop", bus.read, 1'b0);
    check("t6_async_addr_clear", bus.address, '0);
    dmd_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    pulse_resp({32{8'h99}});
    tick();
    check("t6_no_regrant", bus.read, 1'b0);
    push_req(1'b0, 32'h0000_6040, '0);
    push_resp(1'b1, 1'b0, 1'b1, {32{8'hC3}});
    dmd_read = 1'b1; dmd_address = 32'h0000_6040;
    serve({32{8'hC3}}, 1);
    dmd_read = 1'b0;
    repeat (5) tick();

    check("req_queue_drained", req_q.size(), 0);
    check("resp_queue_drained", resp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Shares the single cacheline memory port (cacheline adaptor side) between the L2/LLC demand miss path and the next-line prefetcher.
- Demand traffic has priority; a bounded starvation counter guarantees prefetch progress.
- A demand read to the line a prefetch is already fetching merges onto that prefetch instead of issuing a second memory read.
- Sits between cache/prefetcher and the cacheline adaptor.

Parameters:
STARVE_LIMIT, 8, consecutive demand grants allowed while a prefetch waits before the prefetch must win; 0 = strict demand priority, counter disabled
ADDR_W, 32, address width
LINE_W, 256, cacheline width in bits

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
dmd_read  in  1  demand line read request, held until dmd_resp
dmd_write  in  1  demand line writeback request, held until dmd_resp
dmd_address  in  ADDR_W  demand line address, stable while request held
dmd_wdata  in  LINE_W  writeback data
dmd_rdata  out  LINE_W  read data, valid with dmd_resp
dmd_resp  out  1  one-cycle completion pulse
pf_read  in  1  prefetch read request, held until pf_resp
pf_address  in  ADDR_W  prefetch line address
pf_rdata  out  LINE_W  prefetch data, valid with pf_resp
pf_resp  out  1  one-cycle completion pulse
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_W  line-aligned address
mem_wdata  out  LINE_W  write data
mem_rdata  in  LINE_W  memory read data
mem_resp  in  1  one-cycle memory completion

Behaviour:
- FSM states: IDLE, DMD, PF. Reset (rst low, asynchronous): state=IDLE, starve count=0, merge flag=0, mem_read/mem_write/mem_address/mem_wdata=0. dmd_resp/pf_resp=0 throughout reset.
- Requesters drop their request in the cycle after their resp pulse. dmd_read and dmd_write both high is illegal; write takes precedence.
- IDLE arbitration, evaluated each cycle:
  - Demand only -> DMD.
  - Prefetch only -> PF.
  - Both -> PF if STARVE_LIMIT>0 and count==STARVE_LIMIT, else DMD.
  - Neither -> stay IDLE.
- Grant is registered: mem_read/mem_write, mem_address and mem_wdata are loaded on the transition edge and held constant until mem_resp.
- mem_address[4:0] is forced to 0 in both DMD and PF.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each demand grant made while pf_read is high.
  - Clears on every prefetch grant.
- DMD: on mem_resp, dmd_resp=1 combinationally in the same cycle and dmd_rdata=mem_rdata; next state IDLE.
- PF:
  - On mem_resp: pf_resp=1 and pf_rdata=mem_rdata; next state IDLE.
  - Merge: in any PF cycle with dmd_read=1, dmd_write=0 and dmd_address[31:5]==latched mem_address[31:5], set the merge flag. The flag holds until mem_resp, and the condition is also evaluated in the mem_resp cycle itself.
  - On mem_resp with merge: dmd_resp=1 and dmd_rdata=mem_rdata in the same cycle as pf_resp. The flag clears and the demand is not granted again.
  - A non-matching demand, or any demand write, waits in PF and is granted from IDLE afterwards.
- mem_resp in IDLE is ignored. Outside resp cycles, dmd_rdata/pf_rdata mirror mem_rdata; they are don't-care without their resp.
- Minimum turnaround: after the mem_resp cycle, IDLE for one cycle, then the next strobe rises on the following edge.
- Reset mid-transaction: the FSM aborts to IDLE immediately. No resp is issued for the aborted request.

Decomposition:
- Shared package line_arb_pkg holds:
  - arb_state_t enum (IDLE, DMD, PF)
  - LINE_OFFSET_BITS=5
  - LINE_BYTES=32
- One sub-module: line_arb_starve_ctr (saturating counter with inc/clr and an at_limit output, parameterised by STARVE_LIMIT).

Test Plan:
- Demand read 0x0000_1040 alone -> mem_read=1 and mem_address=0x0000_1040 the cycle after the request; mem_resp with data 0xA5..A5 -> dmd_resp pulse in the same cycle with dmd_rdata=0xA5..A5; pf_resp stays 0.
- dmd_read 0x100 and pf_read 0x120 raised in the same cycle, STARVE_LIMIT=8 -> demand served first; prefetch granted one idle cycle after dmd_resp; mem_address=0x120.
- Prefetch held high while demand reads are issued back to back, STARVE_LIMIT=2 -> demand, demand, prefetch, demand ordering on mem_address; counter clears after the prefetch grant.
- Prefetch 0x2020 in flight; dmd_read 0x2024 raised mid-transaction -> single mem_read only; one mem_resp yields dmd_resp and pf_resp in the same cycle with identical data.
- Prefetch 0x2020 in flight; dmd_write 0x2020 -> no merge; writeback issued after pf_resp with mem_write=1 and mem_wdata=dmd_wdata.
- rst driven low two cycles into a DMD transaction -> mem_read drops asynchronously; mem_resp arriving later is ignored with no resp pulses; a fresh request after reset is serviced normally.
